// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the multiply/divide sequencer.
//   state_t          : sequencer states (IDLE, LAUNCH, WAIT, CAPTURE)
//   OP_MULT / OP_DIV : operation encoding on the op input
//   DEF_*_CYCLES     : default fixed latencies of the external units
//   CNT_W            : width of the iteration counter (latencies up to 64)
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned DEF_MULT_CYCLES = 32'd32;
  localparam int unsigned DEF_DIV_CYCLES  = 32'd32;

  localparam int unsigned CNT_W = 32'd6;

  // The counter is loaded with N-1 so that WAIT lasts exactly N cycles
  // (it spends one cycle on each value N-1 down to 0).
  function automatic logic [CNT_W-1:0] cycles_to_load(input int unsigned cycles);
    int unsigned v;
    v = cycles - 32'd1;
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_cycle_counter.sv
// -----------------------------------------------------------------------------
// cycle_counter
// Loadable down-counter with a zero flag; times the WAIT phase of an
// operation. Load has priority over decrement; decrement saturates at 0.
//   i_clk      : clock
//   i_reset_n  : synchronous active-low reset (count -> 0)
//   i_load     : load i_load_val this cycle
//   i_load_val : value to load
//   i_dec      : decrement by one (ignored when already 0)
//   o_zero     : count is 0
// -----------------------------------------------------------------------------
module cycle_counter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Count register: reset, load, or saturating decrement.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequencer for the external multicycle multiplier and divider. Accepts a
// MULT/DIV request in IDLE, latches the operands, pulses the selected unit's
// init, waits the unit's fixed latency, then captures the result into HI/LO.
// Also generates the MFHI/MFLO stall interlock and rejects divide-by-zero.
//
// Parameters
//   MULT_CYCLES, DIV_CYCLES : cycles from init pulse to valid result (1..64)
// Ports
//   i_clk                   : clock, all logic on posedge
//   i_reset                 : synchronous active-low reset
//   i_start, i_op           : request and operation (OP_MULT / OP_DIV)
//   i_value_a, i_value_b    : operands, valid in the start cycle
//   i_rd_req                : MFHI/MFLO in decode this cycle
//   i_mult_hi, i_mult_lo    : multiplier result
//   i_div_quot, i_div_rem   : divider result
//   o_op_a, o_op_b          : latched operands to both units
//   o_mult_init, o_div_init : one-cycle start pulse to the selected unit
//   o_busy                  : operation in flight
//   o_stall                 : i_rd_req & o_busy (combinational)
//   o_done                  : one-cycle pulse, HI/LO hold the new result
//   o_div_zero              : one-cycle pulse, DIV by zero rejected
//   o_hi, o_lo              : architectural HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [31:0] i_value_a,
  input  logic [31:0] i_value_b,
  input  logic        i_rd_req,
  input  logic [31:0] i_mult_hi,
  input  logic [31:0] i_mult_lo,
  input  logic [31:0] i_div_quot,
  input  logic [31:0] i_div_rem,
  output logic [31:0] o_op_a,
  output logic [31:0] o_op_b,
  output logic        o_mult_init,
  output logic        o_div_init,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_div_zero,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int unsigned MAX_CYCLES = 32'd1 << CNT_W;

  if ((MULT_CYCLES < 32'd1) || (MULT_CYCLES > MAX_CYCLES)) begin : g_bad_mult_cycles
    $error("muldiv_ctrl: MULT_CYCLES out of range");
  end
  if ((DIV_CYCLES < 32'd1) || (DIV_CYCLES > MAX_CYCLES)) begin : g_bad_div_cycles
    $error("muldiv_ctrl: DIV_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] MULT_LOAD = cycles_to_load(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = cycles_to_load(DIV_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_op;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_mult_init;
  logic        r_div_init;
  logic        r_busy;
  logic        r_done;
  logic        r_div_zero;

  logic             w_accept;
  logic             w_reject;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;

  cycle_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_counter (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Next-state and counter control for the sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_reject       = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = MULT_LOAD;
    w_cnt_dec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          // A zero divisor never reaches the divider; it is reported instead.
          if ((i_op == OP_DIV) && (i_value_b == 32'd0)) begin
            w_reject    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_LAUNCH;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        w_cnt_load = 1'b1;
        if (r_op == OP_DIV) begin
          w_cnt_load_val = DIV_LOAD;
        end else begin
          w_cnt_load_val = MULT_LOAD;
        end
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_cnt_dec   = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_CAPTURE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered control pulses and busy flag, all derived one cycle ahead.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_mult_init <= 1'b0;
      r_div_init  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_mult_init <= w_accept && (i_op == OP_MULT);
      r_div_init  <= w_accept && (i_op == OP_DIV);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (r_state == ST_CAPTURE);
      r_div_zero  <= w_reject;
    end
  end

  // Operand and operation latch; held until the next accepted start.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_op   <= OP_MULT;
      r_op_a <= 32'd0;
      r_op_b <= 32'd0;
    end else if (w_accept) begin
      r_op   <= i_op;
      r_op_a <= i_value_a;
      r_op_b <= i_value_b;
    end else begin
      r_op   <= r_op;
      r_op_a <= r_op_a;
      r_op_b <= r_op_b;
    end
  end

  // HI/LO capture. Division follows the MIPS layout: HI = remainder, LO = quotient.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_state == ST_CAPTURE) begin
      if (r_op == OP_DIV) begin
        r_hi <= i_div_rem;
        r_lo <= i_div_quot;
      end else begin
        r_hi <= i_mult_hi;
        r_lo <= i_mult_lo;
      end
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_mult_init = r_mult_init;
  assign o_div_init  = r_div_init;
  assign o_busy      = r_busy;
  // Busy is already low in the done cycle, so an MFHI/MFLO there reads the new value.
  assign o_stall     = i_rd_req & r_busy;
  assign o_done      = r_done;
  assign o_div_zero  = r_div_zero;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Scoreboard bench for muldiv_ctrl with default latencies (32/32). Stimulus
// pushes the expected HI/LO and done cycle for each accepted operation; a
// monitor pops and compares whenever o_done is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int LAT = 35;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_op = 1'b0;
  logic [31:0] i_value_a = 32'd0;
  logic [31:0] i_value_b = 32'd0;
  logic        i_rd_req = 1'b0;
  logic [31:0] mult_hi, mult_lo, div_quot, div_rem;
  logic [31:0] o_op_a, o_op_b, o_hi, o_lo;
  logic        o_mult_init, o_div_init, o_busy, o_stall, o_done, o_div_zero;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath units driven by the latched operands.
  logic [63:0] prod;
  assign prod     = {32'd0, o_op_a} * {32'd0, o_op_b};
  assign mult_hi  = prod[63:32];
  assign mult_lo  = prod[31:0];
  assign div_quot = (o_op_b == 32'd0) ? 32'hFFFF_FFFF : (o_op_a / o_op_b);
  assign div_rem  = (o_op_b == 32'd0) ? o_op_a : (o_op_a % o_op_b);

  muldiv_ctrl dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_value_a   (i_value_a),
    .i_value_b   (i_value_b),
    .i_rd_req    (i_rd_req),
    .i_mult_hi   (mult_hi),
    .i_mult_lo   (mult_lo),
    .i_div_quot  (div_quot),
    .i_div_rem   (div_rem),
    .o_op_a      (o_op_a),
    .o_op_b      (o_op_b),
    .o_mult_init (o_mult_init),
    .o_div_init  (o_div_init),
    .o_busy      (o_busy),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_div_zero  (o_div_zero),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
  );

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest expected result and its cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (o_done === 1'b1) begin
      chk_b("done_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_w("done_cycle", 32'(cyc), 32'(e.cyc));
        chk_w("hi", o_hi, e.hi);
        chk_w("lo", o_lo, e.lo);
        chk_b("busy_in_done", o_busy, 1'b0);
      end
    end
  end

  // Issue one request at the current cycle (C0) and check per-cycle control
  // outputs for C0..C(ncyc). pulse_at > 0 injects an ignored MULT start then.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic rd, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ncyc, input int pulse_at);
    int   k;
    logic ok;
    logic bz;
    exp_t e;
    k  = cyc;
    ok = !((op == OP_DIV) && (b == 32'd0));
    i_start   = 1'b1;
    i_op      = op;
    i_value_a = a;
    i_value_b = b;
    i_rd_req  = rd;
    if (ok) begin
      e.hi = ehi; e.lo = elo; e.cyc = k + LAT;
      sb.push_back(e);
    end
    for (int n = 0; n <= ncyc; n++) begin
      @(negedge clk);
      bz = ok && (n >= 1) && (n <= LAT - 1);
      chk_b("mult_init", o_mult_init, ok && (op == OP_MULT) && (n == 1));
      chk_b("div_init", o_div_init, ok && (op == OP_DIV) && (n == 1));
      chk_b("busy", o_busy, bz);
      chk_b("stall", o_stall, rd && bz);
      chk_b("div_zero", o_div_zero, !ok && (n == 1));
      if (ok && (n >= 1)) begin
        chk_w("op_a", o_op_a, a);
        chk_w("op_b", o_op_b, b);
      end
      @(posedge clk);
      #1;
      i_start = (n + 1 == pulse_at);
      if (n + 1 == pulse_at) begin
        i_op      = OP_MULT;
        i_value_a = 32'd1;
        i_value_b = 32'd1;
      end
    end
    i_start  = 1'b0;
    i_rd_req = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_w("rst_hi", o_hi, 32'd0);
    chk_w("rst_lo", o_lo, 32'd0);
    chk_w("rst_op_a", o_op_a, 32'd0);
    chk_b("rst_busy", o_busy, 1'b0);
    chk_b("rst_done", o_done, 1'b0);
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of WAIT discards the MULT.
    i_start = 1'b1; i_op = OP_MULT; i_value_a = 32'd5; i_value_b = 32'd9;
    repeat (10) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
    end
    @(negedge clk);
    chk_b("midwait_busy", o_busy, 1'b1);
    chk_w("midwait_op_a", o_op_a, 32'd5);
    i_reset = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(negedge clk);
    chk_b("mrst_busy", o_busy, 1'b0);
    chk_w("mrst_op_a", o_op_a, 32'd0);
    chk_w("mrst_op_b", o_op_b, 32'd0);
    chk_w("mrst_hi", o_hi, 32'd0);
    chk_w("mrst_lo", o_lo, 32'd0);
    chk_b("mrst_mult_init", o_mult_init, 1'b0);
    chk_b("mrst_done", o_done, 1'b0);
    repeat (40) @(posedge clk);
    #1;

    // MULT 7*6 with rd_req held from C0: stall C1..C34, none at done.
    run_op(OP_MULT, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42, LAT, -1);
    // DIV by zero: rejected, HI/LO and operands untouched.
    run_op(OP_DIV, 32'd99, 32'd0, 1'b0, 32'd0, 32'd0, 3, -1);
    chk_w("dz_hi", o_hi, 32'd0);
    chk_w("dz_lo", o_lo, 32'd42);
    chk_w("dz_op_a", o_op_a, 32'd7);
    chk_w("dz_op_b", o_op_b, 32'd6);
    // DIV 17/5: HI = remainder 2, LO = quotient 3.
    run_op(OP_DIV, 32'd17, 32'd5, 1'b0, 32'd2, 32'd3, LAT, -1);
    // MULT with a carry into HI: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE.
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd1, 32'hFFFF_FFFE, LAT, -1);
    // Back-to-back: MULT 3*4, DIV 9/2 started in its done cycle, with an
    // ignored start pulsed in the middle of the DIV's WAIT.
    run_op(OP_MULT, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, LAT - 1, -1);
    run_op(OP_DIV, 32'd9, 32'd2, 1'b0, 32'd1, 32'd4, LAT, 10);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_w("pending_results", 32'(sb.size()), 32'd0);
    chk_w("final_hi", o_hi, 32'd1);
    chk_w("final_lo", o_lo, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the multicycle multiply and divide datapaths of the CPU. It accepts a MULT/DIV request from the main control unit and latches the operands. It pulses the selected unit's init, counts that unit's fixed iteration latency, then captures the result into the architectural HI/LO registers. It also produces the stall interlock for MFHI/MFLO issued while an operation is in flight, and flags divide-by-zero.

## Interface
Parameters:
- MULT_CYCLES, 32: cycles from mult_init pulse until mult_hi/mult_lo are valid.
- DIV_CYCLES, 32: cycles from div_init pulse until div_quot/div_rem are valid.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  one clock; reset is synchronous and active-low.
- start  in  1  request from control unit; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV.
- value_A, value_B  in  32 each  source operands, valid in the start cycle.
- rd_req  in  1  MFHI/MFLO in decode this cycle.
- mult_hi, mult_lo  in  32 each  multiplier result.
- div_quot, div_rem  in  32 each  divider result.
- op_A, op_B  out  32 each  latched operands to both units.
- mult_init, div_init  out  1 each  one-cycle start pulse to the unit.
- busy  out  1  operation in flight.
- stall  out  1  combinational: rd_req & busy.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_zero  out  1  one-cycle pulse; DIV with value_B == 0 rejected.
- hi, lo  out  32 each  architectural HI/LO registers.

## Operation
- States: IDLE, LAUNCH, WAIT, CAPTURE.
- IDLE, start=1, op=MULT or op=DIV with value_B≠0:
  - latch op_A←value_A, op_B←value_B and the op.
  - next state LAUNCH.
- IDLE, start=1, op=DIV with value_B==0:
  - stay in IDLE; div_zero=1 next cycle.
  - no init pulse; hi/lo unchanged; op_A/op_B not updated.
- LAUNCH:
  - the selected init is 1 for exactly this cycle.
  - counter loads MULT_CYCLES-1 or DIV_CYCLES-1; next WAIT.
- WAIT: counter decrements each cycle; at 0 → CAPTURE.
- CAPTURE:
  - MULT: hi←mult_hi, lo←mult_lo.
  - DIV: hi←div_rem, lo←div_quot (MIPS convention).
  - next IDLE with done=1 (registered).
- busy = state≠IDLE.
- start while busy is ignored; no queueing. The control unit must not issue it.
- Operands and results are opaque 32-bit values; signedness belongs to the datapaths.
- Reset (reset=0 at a posedge), from any state including mid-operation:
  - state IDLE, counter 0.
  - hi, lo, op_A, op_B all 0.
  - mult_init, div_init, done, div_zero 0; the in-flight result is discarded.

## Timing
- Cycle C0: start high. C1: LAUNCH, init high. C2..C(N+1): WAIT, N = MULT_CYCLES or DIV_CYCLES. C(N+2): CAPTURE. C(N+3): done high, hi/lo updated, busy low.
- Latency start→done = N+3 cycles: 35 with defaults.
- busy is high from C1 to C(N+2) inclusive.
- A new start is accepted in the done cycle, giving back-to-back operations with no gap.
- rd_req in the done cycle does not stall and reads the new hi/lo.
- div_zero is high in C1 only; busy stays low.
- The units must hold results stable from C(N+1) through the CAPTURE cycle. op_A/op_B stay constant from C1 until the next accepted start.

## Structure
- Package muldiv_pkg:
  - state enum (IDLE, LAUNCH, WAIT, CAPTURE).
  - OP_MULT=1'b0, OP_DIV=1'b1.
  - default cycle-count constants.
- Sub-module: cycle_counter, a 6-bit loadable down-counter with a zero flag, used for WAIT.
- The multiplier and divider are instantiated outside, next to this block.

## Test plan
- Reset mid-WAIT (reset=0 at C10 of a MULT) → next cycle all outputs 0, state IDLE, no done ever asserted.
- MULT A=7, B=6 (behavioural mult model with lo=A*B) → mult_init at C1 only, done at C35 with hi=0, lo=42, busy high C1..C34.
- DIV A=17, B=5 → div_init at C1, done at C35 with hi=2, lo=3.
- DIV B=0 → div_zero at C1, no init, busy never high, hi/lo keep prior 0/42.
- rd_req held high from C0 of a MULT → stall=1 C1..C34, stall=0 at C35.
- Back-to-back: MULT 3×4, then start DIV 9/2 in its done cycle → second done 35 cycles later, hi=1, lo=4. A start pulsed mid-WAIT produces no extra done.
